// File: rtl/icache_controller.sv
// icache_controller
//   Direct-mapped instruction cache and fetch sequencer. Hits are served
//   combinationally in the same cycle. A miss stalls the CPU while one
//   16-byte block is read from instruction memory. The line is refilled
//   and the fetch is then replayed as a hit. Saturating hit and miss
//   counters are kept for performance runs.
// Ports:
//   clock, reset_n        clock, asynchronous active-low reset
//   read, pc              CPU fetch request and byte address (pc[1:0] ignored)
//   instruction           fetched word from the indexed line
//   cpu_busywait          stall to the CPU
//   mem_read, mem_address block read request and {tag, index} block address
//   mem_readinst          128-bit block from memory, byte 0 in [7:0]
//   mem_busywait          memory busy
//   hit_count, miss_count saturating performance counters
module icache_controller #(
  parameter int LINES = 8,
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             read,
  input  logic [9:0]       pc,
  output logic [31:0]      instruction,
  output logic             cpu_busywait,
  output logic             mem_read,
  output logic [5:0]       mem_address,
  input  logic [127:0]     mem_readinst,
  input  logic             mem_busywait,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count
);

  typedef enum logic [1:0] {IDLE, MEM_READ, UPDATE} state_t;

  state_t       state;
  logic         first;
  logic [LINES-1:0] valid;
  logic [2:0]   tag_store [LINES];
  logic [127:0] data      [LINES];

  logic [2:0] tag;
  logic [2:0] index;
  logic [1:0] offset;
  logic       hit;
  logic       unused_pc_bits;

  assign tag    = pc[9:7];
  assign index  = pc[6:4];
  assign offset = pc[3:2];
  assign unused_pc_bits = ^pc[1:0];

  assign hit         = read & valid[index] & (tag_store[index] == tag);
  assign instruction = data[index][{offset, 5'b00000} +: 32];

  always_comb begin
    cpu_busywait = 1'b1;
    if (state == IDLE) cpu_busywait = read & ~hit;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      first       <= 1'b0;
      mem_read    <= 1'b0;
      mem_address <= '0;
      hit_count   <= '0;
      miss_count  <= '0;
      valid       <= '0;
      for (int unsigned i = 0; i < LINES; i++) begin
        tag_store[i] <= '0;
        data[i]      <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (read) begin
            if (hit) begin
              if (hit_count != '1) hit_count <= hit_count + CNT_W'(1);
            end else begin
              if (miss_count != '1) miss_count <= miss_count + CNT_W'(1);
              mem_address <= {tag, index};
              mem_read    <= 1'b1;
              first       <= 1'b1;
              state       <= MEM_READ;
            end
          end
        end
        MEM_READ: begin
          // The memory raises busywait combinationally from mem_read, so the
          // first edge in this state cannot carry valid data.
          if (first) begin
            first <= 1'b0;
          end else if (!mem_busywait) begin
            data[mem_address[2:0]]      <= mem_readinst;
            tag_store[mem_address[2:0]] <= mem_address[5:3];
            valid[mem_address[2:0]]     <= 1'b1;
            mem_read                    <= 1'b0;
            state                       <= UPDATE;
          end
        end
        UPDATE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
